// File: rtl/sram_100_qsys_sram_arbiter.sv
// Round-robin two-port Avalon-MM front end for the single asynchronous 16-bit SRAM.
// Every access runs IDLE -> ACCESS (ACCESS_CYCLES strobe cycles) -> DONE; the IDLE after DONE is the bus turnaround.
`timescale 1ns/1ps
module sram_100_qsys_sram_arbiter #(
  parameter int ADDR_W        = 18,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_address,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [15:0]       a_writedata,
  input  logic [1:0]        a_byteenable,
  output logic [15:0]       a_readdata,
  output logic              a_waitrequest,
  input  logic [ADDR_W-1:0] b_address,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [15:0]       b_writedata,
  input  logic [1:0]        b_byteenable,
  output logic [15:0]       b_readdata,
  output logic              b_waitrequest,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              grant;       // 0 = port A, 1 = port B
  logic              last_grant;
  logic              is_write;
  logic [15:0]       readdata_q;

  logic              req_a;
  logic              req_b;
  logic              pick_b;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       sel_wdata;
  logic [1:0]        sel_be;

  assign req_a = a_read | a_write;
  assign req_b = b_read | b_write;

  // On a tie the port that did not win last time gets the bus.
  assign pick_b    = req_b & (~req_a | ~last_grant);
  assign sel_write = pick_b ? b_write      : a_write;
  assign sel_addr  = pick_b ? b_address    : a_address;
  assign sel_wdata = pick_b ? b_writedata  : a_writedata;
  assign sel_be    = pick_b ? b_byteenable : a_byteenable;

  assign a_readdata    = readdata_q;
  assign b_readdata    = readdata_q;
  assign a_waitrequest = !((state == S_DONE) && (grant == 1'b0));
  assign b_waitrequest = !((state == S_DONE) && (grant == 1'b1));

  // NOTE: all registered state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      is_write    <= 1'b0;
      readdata_q  <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          sram_dq_oe <= 1'b0;
          if (req_a || req_b) begin
            grant      <= pick_b;
            last_grant <= pick_b;
            is_write   <= sel_write;
            sram_addr  <= sel_addr;
            if (sel_write) begin
              sram_dq_out <= sel_wdata;
              sram_dq_oe  <= 1'b1;
            end
            sram_ce_n <= 1'b0;
            // Reads always fetch the full word; byte lanes only gate writes.
            sram_ub_n <= sel_write ? ~sel_be[1] : 1'b0;
            sram_lb_n <= sel_write ? ~sel_be[0] : 1'b0;
            sram_oe_n <= sel_write;
            sram_we_n <= ~sel_write;
            cnt       <= 4'(ACCESS_CYCLES - 1);
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt == 4'd0) begin
            if (!is_write) readdata_q <= sram_dq_in;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          // Write data was held through DONE; release the bus for the turnaround cycle.
          sram_dq_oe <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_100_qsys_sram_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a randomized
// phase scored against a transaction-level model of arbitration, latency and memory contents.
`timescale 1ns/1ps
module tb_sram_100_qsys_sram_arbiter;

  localparam int ADDR_W = 18;
  localparam int AC     = 2;
  localparam int AC1    = 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] a_address, b_address;
  logic              a_read, a_write, b_read, b_write;
  logic [15:0]       a_writedata, b_writedata;
  logic [1:0]        a_byteenable, b_byteenable;

  logic [15:0]       a_readdata, b_readdata;
  logic              a_waitrequest, b_waitrequest;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_out, sram_dq_in;
  logic              sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  logic [15:0]       a_readdata_1, b_readdata_1;
  logic              a_waitrequest_1, b_waitrequest_1;
  logic [ADDR_W-1:0] sram_addr_1;
  logic [15:0]       sram_dq_out_1, sram_dq_in_1;
  logic              sram_dq_oe_1, sram_ce_n_1, sram_oe_n_1, sram_we_n_1, sram_ub_n_1, sram_lb_n_1;

  sram_100_qsys_sram_arbiter #(.ADDR_W(ADDR_W), .ACCESS_CYCLES(AC)) dut (
    .clock(clock), .reset(reset),
    .a_address(a_address), .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata),
    .a_byteenable(a_byteenable), .a_readdata(a_readdata), .a_waitrequest(a_waitrequest),
    .b_address(b_address), .b_read(b_read), .b_write(b_write), .b_writedata(b_writedata),
    .b_byteenable(b_byteenable), .b_readdata(b_readdata), .b_waitrequest(b_waitrequest),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  sram_100_qsys_sram_arbiter #(.ADDR_W(ADDR_W), .ACCESS_CYCLES(AC1)) dut1 (
    .clock(clock), .reset(reset),
    .a_address(a_address), .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata),
    .a_byteenable(a_byteenable), .a_readdata(a_readdata_1), .a_waitrequest(a_waitrequest_1),
    .b_address(b_address), .b_read(b_read), .b_write(b_write), .b_writedata(b_writedata),
    .b_byteenable(b_byteenable), .b_readdata(b_readdata_1), .b_waitrequest(b_waitrequest_1),
    .sram_addr(sram_addr_1), .sram_dq_out(sram_dq_out_1), .sram_dq_oe(sram_dq_oe_1), .sram_dq_in(sram_dq_in_1),
    .sram_ce_n(sram_ce_n_1), .sram_oe_n(sram_oe_n_1), .sram_we_n(sram_we_n_1),
    .sram_ub_n(sram_ub_n_1), .sram_lb_n(sram_lb_n_1)
  );

  always #5 clock = ~clock;

  // Asynchronous SRAM model with byte lanes for the main instance.
  bit [15:0] sram_mem [0:(1<<ADDR_W)-1];
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'h0000;
  always @(posedge clock) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (!sram_ub_n) sram_mem[sram_addr][15:8] <= sram_dq_out[15:8];
      if (!sram_lb_n) sram_mem[sram_addr][7:0]  <= sram_dq_out[7:0];
    end
  end

  // The single-cycle instance reads an address-derived pattern.
  assign sram_dq_in_1 = (!sram_ce_n_1 && !sram_oe_n_1) ? (sram_addr_1[15:0] ^ 16'hC3A5) : 16'h0000;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    a_address = '0; a_read = 0; a_write = 0; a_writedata = '0; a_byteenable = '0;
    b_address = '0; b_read = 0; b_write = 0; b_writedata = '0; b_byteenable = '0;
  endtask

  task automatic set_port(input bit p, input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                          input logic [15:0] wdata, input logic [1:0] be);
    if (p == 1'b0) begin
      a_read = rd; a_write = wr; a_address = addr; a_writedata = wdata; a_byteenable = be;
    end else begin
      b_read = rd; b_write = wr; b_address = addr; b_writedata = wdata; b_byteenable = be;
    end
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    tick();
    tick();
    reset = 0;
  endtask

  // One complete transaction on a single port, starting in an IDLE cycle.
  task automatic do_xfer(input bit p, input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                         input logic [15:0] wdata, input logic [1:0] be, input string tag,
                         output logic [15:0] rdata);
    int  lat = -1;
    int  strobe = 0;
    bit  pins_bad = 0;
    bit  other_low = 0;
    rdata = '0;
    set_port(p, rd, wr, addr, wdata, be);
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (!sram_we_n || !sram_oe_n) begin
        strobe++;
        if (sram_addr !== addr || sram_ce_n !== 1'b0) pins_bad = 1;
        if (wr) begin
          if (sram_we_n !== 1'b0 || sram_oe_n !== 1'b1 || sram_dq_out !== wdata ||
              {sram_ub_n, sram_lb_n} !== ~be || sram_dq_oe !== 1'b1) pins_bad = 1;
        end else begin
          if (sram_oe_n !== 1'b0 || sram_we_n !== 1'b1 || {sram_ub_n, sram_lb_n} !== 2'b00) pins_bad = 1;
        end
      end
      if ((p ? a_waitrequest : b_waitrequest) !== 1'b1) other_low = 1;
      if ((p ? b_waitrequest : a_waitrequest) === 1'b0) begin
        lat = n;
        rdata = p ? b_readdata : a_readdata;
        break;
      end
    end
    set_port(p, 0, 0, '0, '0, '0);
    check({tag, " latency"}, lat, AC + 1);
    check({tag, " strobe cycles"}, strobe, AC);
    check({tag, " pins during strobe"}, {31'd0, pins_bad}, 0);
    check({tag, " other port waitrequest"}, {31'd0, other_low}, 0);
    tick();
    check({tag, " turnaround pins ce/oe/we/oe_dq"}, {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
  endtask

  typedef struct {
    bit              port;
    bit              rd;
    bit              wr;
    logic [ADDR_W-1:0] addr;
    logic [15:0]     wdata;
    logic [1:0]      be;
    logic [15:0]     exp_rdata;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #400000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd_val;
    idle_inputs();
    vecs[0] = '{0, 0, 1, 18'h00010, 16'h1234, 2'b11, 16'h0000};
    vecs[1] = '{0, 1, 0, 18'h00010, 16'h0000, 2'b11, 16'h1234};
    vecs[2] = '{1, 0, 1, 18'h00020, 16'hABCD, 2'b10, 16'h0000};
    vecs[3] = '{1, 1, 0, 18'h00020, 16'h0000, 2'b11, 16'hAB00};
    vecs[4] = '{0, 0, 1, 18'h00030, 16'h5678, 2'b01, 16'h0000};
    vecs[5] = '{0, 1, 0, 18'h00030, 16'h0000, 2'b11, 16'h0078};
    vecs[6] = '{1, 0, 1, 18'h00010, 16'hFFFF, 2'b00, 16'h0000};
    vecs[7] = '{1, 1, 0, 18'h00010, 16'h0000, 2'b11, 16'h1234};
    vecs[8] = '{0, 1, 1, 18'h00040, 16'h9999, 2'b11, 16'h0000};
    vecs[9] = '{1, 1, 0, 18'h00040, 16'h0000, 2'b11, 16'h9999};

    // Reset values, sampled while reset is still asserted.
    tick();
    tick();
    check("reset pins ce/oe/we/ub/lb", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
    check("reset dq_oe", sram_dq_oe, 0);
    check("reset sram_addr", sram_addr, 0);
    check("reset dq_out", sram_dq_out, 0);
    check("reset readdata", a_readdata, 0);
    check("reset waitrequests", {a_waitrequest, b_waitrequest}, 2'b11);
    reset = 0;
    tick();

    // Directed vectors, one transaction at a time.
    foreach (vecs[i]) begin
      do_xfer(vecs[i].port, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
              $sformatf("vec%0d", i), rd_val);
      if (vecs[i].rd && !vecs[i].wr) check($sformatf("vec%0d readdata", i), rd_val, vecs[i].exp_rdata);
    end

    // Simultaneous requests right after reset, held continuously: A, B, A, B.
    begin
      int  done_cnt = 0;
      bit  exp_port = 0;
      do_reset();
      set_port(0, 1, 0, 18'h00010, '0, 2'b11);
      set_port(1, 1, 0, 18'h00020, '0, 2'b11);
      for (int n = 1; n <= 40; n++) begin
        tick();
        if (a_waitrequest === 1'b0 || b_waitrequest === 1'b0) begin
          bit who;
          who = (a_waitrequest === 1'b0) ? 1'b0 : 1'b1;
          check("rr exclusive completion", {a_waitrequest, b_waitrequest}, who ? 2'b10 : 2'b01);
          check("rr order", who, exp_port);
          check("rr completion cycle", n, (AC + 1) + (AC + 2) * done_cnt);
          check("rr readdata", who ? b_readdata : a_readdata, who ? 16'hAB00 : 16'h1234);
          done_cnt++;
          exp_port = ~exp_port;
          if (done_cnt == 4) break;
        end
      end
      idle_inputs();
      check("rr completions", done_cnt, 4);
      tick();
    end

    // Reset asserted in the ACCESS cycle of a write aborts it silently.
    begin
      bit saw_low = 0;
      do_reset();
      set_port(0, 0, 1, 18'h00050, 16'h7777, 2'b11);
      tick();
      check("abort in access we_n", sram_we_n, 0);
      reset = 1;
      tick();
      idle_inputs();
      reset = 0;
      check("abort pins ce/we/oe_dq", {sram_ce_n, sram_we_n, sram_dq_oe}, 3'b110);
      check("abort waitrequests", {a_waitrequest, b_waitrequest}, 2'b11);
      for (int n = 0; n < 8; n++) begin
        tick();
        if (a_waitrequest !== 1'b1 || b_waitrequest !== 1'b1 || sram_ce_n !== 1'b1) saw_low = 1;
      end
      check("abort no completion", saw_low, 0);
      do_xfer(0, 1, 0, 18'h00010, '0, 2'b11, "post-abort read", rd_val);
      check("post-abort readdata", rd_val, 16'h1234);
    end

    // Randomized traffic against a transaction-level reference model.
    begin
      bit [15:0] ref_mem [0:7];
      bit        model_last;
      do_reset();
      model_last = 1'b1;
      foreach (ref_mem[i]) ref_mem[i] = '0;
      for (int r = 0; r < 40; r++) begin
        bit              active [2];
        bit              is_rd [2];
        bit              is_wr [2];
        logic [2:0]      idx [2];
        logic [15:0]     wd [2];
        logic [1:0]      bev [2];
        int              exp_lat [2];
        logic [15:0]     exp_data [2];
        int              got_lat [2];
        logic [15:0]     got_data [2];
        bit              order [2];
        int              mode;
        int              n_act;
        mode = $urandom_range(0, 2);
        active[0] = (mode != 1);
        active[1] = (mode != 0);
        for (int p = 0; p < 2; p++) begin
          int op;
          op = $urandom_range(0, 2);
          is_rd[p] = (op != 1);
          is_wr[p] = (op != 0);
          idx[p] = 3'($urandom_range(0, 7));
          wd[p] = 16'($urandom);
          bev[p] = 2'($urandom_range(0, 3));
          got_lat[p] = -1;
          got_data[p] = '0;
          exp_lat[p] = 0;
          exp_data[p] = '0;
        end
        // Grant order: a lone requester wins; on a tie the port not granted last time wins.
        if (active[0] && active[1]) begin
          order[0] = ~model_last;
          order[1] = model_last;
          n_act = 2;
        end else begin
          order[0] = active[1];
          order[1] = 1'b0;
          n_act = 1;
        end
        for (int k = 0; k < n_act; k++) begin
          bit p;
          p = order[k];
          exp_lat[p] = (AC + 1) + k * (AC + 2);
          if (is_wr[p]) begin
            if (bev[p][1]) ref_mem[idx[p]][15:8] = wd[p][15:8];
            if (bev[p][0]) ref_mem[idx[p]][7:0]  = wd[p][7:0];
          end else begin
            exp_data[p] = ref_mem[idx[p]];
          end
          model_last = p;
        end
        for (int p = 0; p < 2; p++)
          if (active[p]) set_port(p[0], is_rd[p], is_wr[p], 18'h00100 + 18'(idx[p]), wd[p], bev[p]);
        for (int n = 1; n <= 30; n++) begin
          tick();
          if (active[0] && got_lat[0] < 0 && a_waitrequest === 1'b0) begin
            got_lat[0] = n; got_data[0] = a_readdata; set_port(0, 0, 0, '0, '0, '0);
          end
          if (active[1] && got_lat[1] < 0 && b_waitrequest === 1'b0) begin
            got_lat[1] = n; got_data[1] = b_readdata; set_port(1, 0, 0, '0, '0, '0);
          end
          if ((!active[0] || got_lat[0] > 0) && (!active[1] || got_lat[1] > 0)) break;
        end
        idle_inputs();
        tick();
        for (int p = 0; p < 2; p++) begin
          if (active[p]) begin
            check($sformatf("rand%0d port%0d latency", r, p), got_lat[p], exp_lat[p]);
            if (!is_wr[p]) check($sformatf("rand%0d port%0d readdata", r, p), got_data[p], exp_data[p]);
          end
        end
      end
    end

    // ACCESS_CYCLES = 1 instance: back-to-back reads every 3 cycles.
    begin
      int last_done = -1;
      int k = 0;
      int oe_hi_run = 0;
      int min_gap = 99;
      bit seen_strobe = 0;
      do_reset();
      set_port(0, 1, 0, 18'h00200, '0, 2'b11);
      for (int n = 1; n <= 40; n++) begin
        tick();
        if (sram_oe_n_1) begin
          oe_hi_run++;
        end else begin
          if (seen_strobe && oe_hi_run < min_gap) min_gap = oe_hi_run;
          seen_strobe = 1;
          oe_hi_run = 0;
        end
        if (a_waitrequest_1 === 1'b0) begin
          logic [15:0] exp_rd;
          exp_rd = a_address[15:0] ^ 16'hC3A5;
          check($sformatf("ac1 read%0d data", k), a_readdata_1, exp_rd);
          if (k == 0) check("ac1 first latency", n, AC1 + 1);
          else        check($sformatf("ac1 read%0d interval", k), n - last_done, AC1 + 2);
          last_done = n;
          k++;
          if (k == 4) break;
          a_address = 18'h00200 + 18'(k * 7);
        end
      end
      idle_inputs();
      check("ac1 completions", k, 4);
      check("ac1 oe_n gap at least 2", {31'd0, (min_gap >= 2)}, 1);
      tick();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
